// File: rtl/multicycle_controller.sv
// Control FSM for the shared-ALU, shared-memory multicycle RISC-V datapath.
// Sequences fetch/decode/execute/memory/writeback and tracks retirements and traps.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             wb_sel,
    output logic             illegal_instr,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired_count,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_WB_MEM    = 4'd6,
        S_EXEC_ALUI = 4'd7,
        S_WB_ALU    = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd10
    } state_t;

    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // The stall counter only needs to reach MEM_TIMEOUT-1; the next stall traps.
    localparam int STALL_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0]   count_q;
    logic               illegal_q, timeout_q;
    logic               retire, setIllegal, setTimeout, memWait;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            stall_q   <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            if (retire)     count_q   <= count_q + CNT_W'(1);
            if (setIllegal) illegal_q <= 1'b1;
            if (setTimeout) timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        stall_d    = '0;
        retire     = 1'b0;
        setIllegal = 1'b0;
        setTimeout = 1'b0;
        memWait    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        wb_sel     = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    memWait = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                if (opcode == OP_ALUI) begin
                    state_d = S_EXEC_ALUI;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEM_ADDR;
                end else if (opcode == OP_BRANCH && funct3[2:1] == 2'b00) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d    = S_TRAP;
                    setIllegal = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
                else           memWait = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    memWait = 1'b1;
                end
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_EXEC_ALUI: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = alu_zero ^ funct3[0];
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        // A completing handshake never reaches here, so completion beats the timeout.
        if (memWait && MEM_TIMEOUT > 0) begin
            if (stall_q == STALL_LAST) begin
                state_d    = S_TRAP;
                setTimeout = 1'b1;
            end else begin
                stall_d = stall_q + STALL_W'(1);
            end
        end
    end

    assign illegal_instr = illegal_q;
    assign mem_timeout   = timeout_q;
    assign retired_count = count_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: random instruction streams
// against a per-instruction phase model, plus directed trap/reset scenarios.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic        reg_write, wb_sel, illegal_instr, mem_timeout;
    logic [31:0] retired_count;
    logic [3:0]  state_dbg;
    logic [15:0] obsOuts;

    int          checks = 0;
    int          errors = 0;
    int          cycleNo = 0;
    logic [31:0] expRet = '0;

    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Expected behaviour of one clock cycle of an instruction's life.
    typedef struct {
        logic [3:0]  st;
        logic [15:0] outs;
        logic        rdy;
        logic        rets;
    } cyc_t;

    cyc_t trace[$];

    multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout),
        .retired_count(retired_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign obsOuts = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel,
                      alu_src_a, alu_src_b, alu_op, illegal_instr, mem_timeout};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cycleNo, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic z, input logic rdy);
        opcode    = opc;
        funct3    = f3;
        alu_zero  = z;
        mem_ready = rdy;
    endtask

    // ctl = {req, we, asel, irw, pcw, pcs, rw, wbs}; flags are expected clear.
    function automatic void pushCyc(input logic [3:0] st, input logic [7:0] ctl, input logic [1:0] as,
                                    input logic [1:0] bs, input logic [1:0] op, input logic rdy, input logic rets);
        cyc_t c;
        c.st   = st;
        c.outs = {ctl, as, bs, op, 2'b00};
        c.rdy  = rdy;
        c.rets = rets;
        trace.push_back(c);
    endfunction

    function automatic logic rndBit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void buildFetch(input int stalls);
        for (int i = 0; i < stalls; i++) pushCyc(4'd1, 8'b1000_0000, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        pushCyc(4'd1, 8'b1001_1000, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0);
        pushCyc(4'd2, 8'b0000_0000, 2'b10, 2'b10, 2'b00, rndBit(), 1'b0);
    endfunction

    // Phase list of a whole instruction: fetch, decode, then the per-class tail.
    function automatic void buildInstr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                                       input int fStall, input int mStall);
        buildFetch(fStall);
        case (opc)
            OP_ALUI: begin
                pushCyc(4'd7, 8'b0000_0000, 2'b01, 2'b10, 2'b10, rndBit(), 1'b0);
                pushCyc(4'd8, 8'b0000_0010, 2'b00, 2'b00, 2'b00, rndBit(), 1'b1);
            end
            OP_LOAD: begin
                pushCyc(4'd3, 8'b0000_0000, 2'b01, 2'b10, 2'b00, rndBit(), 1'b0);
                for (int i = 0; i < mStall; i++) pushCyc(4'd4, 8'b1010_0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
                pushCyc(4'd4, 8'b1010_0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
                pushCyc(4'd6, 8'b0000_0011, 2'b00, 2'b00, 2'b00, rndBit(), 1'b1);
            end
            OP_STORE: begin
                pushCyc(4'd3, 8'b0000_0000, 2'b01, 2'b10, 2'b00, rndBit(), 1'b0);
                for (int i = 0; i < mStall; i++) pushCyc(4'd5, 8'b1110_0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
                pushCyc(4'd5, 8'b1110_0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
            end
            default: begin
                pushCyc(4'd9, {4'b0000, z ^ f3[0], 1'b1, 2'b00}, 2'b01, 2'b00, 2'b01, rndBit(), 1'b1);
            end
        endcase
    endfunction

    task automatic runTrace(input logic [6:0] opc, input logic [2:0] f3, input logic z);
        cyc_t c;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            applyStimulus(opc, f3, z, c.rdy);
            #1;
            checkOutput("state", 32'(state_dbg), 32'(c.st));
            checkOutput("outs", 32'(obsOuts), 32'(c.outs));
            checkOutput("retired", retired_count, expRet);
            if (c.rets) expRet = expRet + 32'd1;
            cycleNo++;
            @(negedge clk);
        end
    endtask

    // Assert reset now, check the cleared state, release on the next falling edge
    // and check the IDLE cycle; returns with the DUT in FETCH.
    task automatic doReset(input string tag);
        reset = 1'b1;
        #1;
        checkOutput({tag, "_rstState"}, 32'(state_dbg), 32'd0);
        checkOutput({tag, "_rstOuts"}, 32'(obsOuts), 32'd0);
        checkOutput({tag, "_rstCount"}, retired_count, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        expRet = '0;
        #1;
        checkOutput({tag, "_idleState"}, 32'(state_dbg), 32'd0);
        checkOutput({tag, "_idleOuts"}, 32'(obsOuts), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] opc;
        logic [2:0] f3;
        logic       z;
        int         kind;

        reset = 1'b1;
        applyStimulus(7'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        doReset("init");

        // Directed: addi, lw with 3 stalls, beq taken, bne not taken.
        buildInstr(OP_ALUI, 3'b000, 1'b0, 0, 0);   runTrace(OP_ALUI, 3'b000, 1'b0);
        buildInstr(OP_LOAD, 3'b010, 1'b0, 0, 3);   runTrace(OP_LOAD, 3'b010, 1'b0);
        buildInstr(OP_BRANCH, 3'b000, 1'b1, 0, 0); runTrace(OP_BRANCH, 3'b000, 1'b1);
        buildInstr(OP_BRANCH, 3'b001, 1'b1, 0, 0); runTrace(OP_BRANCH, 3'b001, 1'b1);
        checkOutput("retiredAfterDirected", retired_count, 32'd4);

        // Random instruction stream.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            z    = rndBit();
            f3   = 3'($urandom_range(0, 7));
            case (kind)
                0: opc = OP_ALUI;
                1: opc = OP_LOAD;
                2: opc = OP_STORE;
                default: begin
                    opc = OP_BRANCH;
                    f3  = {2'b00, rndBit()};
                end
            endcase
            buildInstr(opc, f3, z, $urandom_range(0, 3), $urandom_range(0, 3));
            runTrace(opc, f3, z);
        end

        // Reset in the middle of a stalled store: the store must not retire.
        buildFetch(0);
        pushCyc(4'd3, 8'b0000_0000, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0);
        pushCyc(4'd5, 8'b1110_0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        pushCyc(4'd5, 8'b1110_0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        runTrace(OP_STORE, 3'b010, 1'b0);
        #3;
        checkOutput("stallReqBeforeReset", 32'({mem_req, mem_we}), 32'd3);
        doReset("midStore");

        // Unsupported opcode traps after decode and sticks until reset.
        buildFetch(0);
        runTrace(OP_LUI, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_ALUI, 3'b000, 1'b0, 1'b1);
            #1;
            checkOutput("illegalState", 32'(state_dbg), 32'd10);
            checkOutput("illegalOuts", 32'(obsOuts), 32'h0002);
            @(negedge clk);
        end
        doReset("illegal");

        // Fifteen consecutive fetch stalls trap with mem_timeout.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(OP_ALUI, 3'b000, 1'b0, 1'b0);
            #1;
            checkOutput("timeoutFetch", 32'(state_dbg), 32'd1);
            @(negedge clk);
        end
        #1;
        checkOutput("timeoutState", 32'(state_dbg), 32'd10);
        checkOutput("timeoutOuts", 32'(obsOuts), 32'h0001);
        @(negedge clk);
        doReset("timeout");

        // Completion on the cycle that would otherwise time out wins.
        buildFetch(14);
        runTrace(OP_ALUI, 3'b000, 1'b0);
        checkOutput("noTimeoutState", 32'(state_dbg), 32'd7);
        checkOutput("noTimeoutFlag", 32'(mem_timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy control FSM that sequences the shared single-ALU, single-memory RISC-V datapath through fetch, decode, execute, memory and writeback.
- Supports the instruction subset decoded by the immediate generator: I-type ALU (0010011), load (0000011), store (0100011) and branch (1100011, beq/bne).
- Drives the datapath mux selects, register/PC/IR write enables and a req/ready memory handshake.
- Reports a retired-instruction count and sticky trap flags.

Parameters:
- MEM_TIMEOUT, 15, maximum consecutive stall cycles in a memory state before trapping; 0 disables the timeout.
- CNT_W, 32, width of retired_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  instruction[6:0] from the IR.
- funct3  in  3  instruction[14:12] from the IR.
- alu_zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write request (store).
- addr_sel  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  latch instruction and old PC.
- pc_write  out  1  PC load enable.
- pc_src  out  1  PC source: 0 = ALU result (PC+4), 1 = ALUOut (branch target).
- alu_src_a  out  2  ALU A: 00 = PC, 01 = rs1, 10 = old PC.
- alu_src_b  out  2  ALU B: 00 = rs2, 01 = constant 4, 10 = imm_extended.
- alu_op  out  2  00 = ADD, 01 = SUB, 10 = funct3-directed.
- reg_write  out  1  register file write enable.
- wb_sel  out  1  writeback data: 0 = ALUOut, 1 = memory data.
- illegal_instr  out  1  sticky; unsupported opcode or branch funct3.
- mem_timeout  out  1  sticky; memory stall exceeded MEM_TIMEOUT.
- retired_count  out  CNT_W  instructions completed, wraps modulo 2^CNT_W.
- state_dbg  out  4  current state encoding.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WRITE=5, WB_MEM=6, EXEC_ALUI=7, WB_ALU=8, BRANCH=9, TRAP=10.
- Reset asserted, at any time including mid-handshake: state forced to IDLE immediately. All outputs, retired_count, sticky flags and the stall counter go to 0.
- Any output not listed for a state is 0.
- IDLE: all outputs 0; always goes to FETCH next cycle.
- FETCH:
  - Outputs: mem_req=1, addr_sel=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - When mem_ready=1 (same cycle, Mealy): ir_write=1, pc_write=1, pc_src=0; go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0010011 -> EXEC_ALUI.
  - 0000011 or 0100011 -> MEM_ADDR.
  - 1100011 with funct3 000/001 -> BRANCH.
  - Anything else -> TRAP, illegal_instr=1.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Load -> MEM_READ; store -> MEM_WRITE.
- MEM_READ: mem_req=1, addr_sel=1. On mem_ready go to WB_MEM; otherwise stay.
- MEM_WRITE: mem_req=1, mem_we=1, addr_sel=1. On mem_ready go to FETCH and retire; otherwise stay.
- WB_MEM: reg_write=1, wb_sel=1 -> FETCH, retire.
- EXEC_ALUI: alu_src_a=01, alu_src_b=10, alu_op=10 -> WB_ALU.
- WB_ALU: reg_write=1, wb_sel=0 -> FETCH, retire.
- BRANCH:
  - Outputs: alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_write = alu_zero XOR funct3[0] (beq taken on zero, bne taken on non-zero).
  - Always -> FETCH, retire.
- TRAP: all outputs 0 except the sticky flags; remains in TRAP until reset.
- Retire: retired_count increments by 1 on the clock edge leaving WB_ALU, WB_MEM, BRANCH, or MEM_WRITE with mem_ready. Wraps from all-ones to 0.
- Stall counter (MEM_TIMEOUT > 0):
  - Increments each cycle in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Clears on mem_ready or on leaving the state.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: next state TRAP, mem_timeout=1.
  - If mem_ready=1 in the same cycle the count would reach MEM_TIMEOUT, the completion wins.
- mem_req: once asserted, stays high and address/we stay stable until mem_ready, reset, or timeout.
- Zero-wait latencies, in cycles: addi 4, lw 5, sw 4, beq/bne 3, plus one IDLE cycle after reset.

Test Plan:
- addi (opcode 0010011), mem_ready tied 1 -> state sequence 1,2,7,8,1; reg_write=1 only in state 8; retired_count 0 -> 1 after 4 cycles.
- lw with mem_ready low 3 cycles in MEM_READ -> mem_req and addr_sel=1 held stable for 4 cycles; WB_MEM has wb_sel=1; total 8 cycles.
- beq, alu_zero=1 -> pc_write=1, pc_src=1 in BRANCH; bne (funct3=001), alu_zero=1 -> pc_write=0; each retires one instruction.
- Opcode 0110111 -> TRAP after DECODE; illegal_instr=1 persists, no mem_req; reset returns to IDLE then FETCH with flags cleared.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> TRAP after the 15th stall cycle, mem_timeout=1. Variant: mem_ready=1 on that same cycle -> DECODE, no trap.
- Reset asserted mid-MEM_WRITE stall -> mem_req and mem_we drop asynchronously; retired_count=0; the store is not retired.
